// File: rtl/glyph_frame_sequencer_pkg.sv
// Shared types and constants for the glyph frame sequencer.
// GLYPH_SEQ_LFSR_EN selects LFSR scrambling; otherwise the scramble seed is a plain counter.
package glyph_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_CYCLE    = 2'd1,
        MODE_SCRAMBLE = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_MODE_W   = 2;
    localparam int CFG_ARG_LSB  = 2;
    localparam int CFG_ARG_W    = 6;

    localparam int DEF_GLYPH_H   = 12;
    localparam int DEF_H_TOTAL   = 800;
    localparam int DEF_V_TOTAL   = 525;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_PALETTE_N = 8;

`ifdef GLYPH_SEQ_LFSR_EN
    localparam logic [4:0] SCRAMBLE_SEED = 5'b00001;
`else
    localparam logic [4:0] SCRAMBLE_SEED = 5'b00000;
`endif

    function automatic logic [4:0] scramble_step(input logic [4:0] s);
`ifdef GLYPH_SEQ_LFSR_EN
        return {s[3:0], s[4] ^ s[2]};
`else
        return s + 5'd1;
`endif
    endfunction

endpackage

// File: rtl/glyph_frame_sequencer_if.sv
// Valid/ready configuration port of the glyph frame sequencer.
interface glyph_frame_sequencer_if;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/glyph_frame_sequencer_line_counter.sv
// Glyph row / line-within-glyph tracker, advanced once per line and cleared at the frame boundary.
module glyph_line_counter #(
    parameter int GLYPH_H  = 12,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_line_end,
    input  logic       i_frame_end,
    input  logic [9:0] i_vpos,
    output logic [5:0] o_row_block,
    output logic [3:0] o_glyph_line
);
    logic [10:0] w_next_line;
    logic [5:0]  r_row_block;
    logic [3:0]  r_glyph_line;

    assign w_next_line = {1'b0, i_vpos} + 11'd1;

    // Counters freeze once the next line falls into vertical blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_block  <= '0;
            r_glyph_line <= '0;
        end else if (i_frame_end) begin
            r_row_block  <= '0;
            r_glyph_line <= '0;
        end else if (i_line_end && (w_next_line < 11'(V_ACTIVE))) begin
            if (r_glyph_line == 4'(GLYPH_H - 1)) begin
                r_glyph_line <= '0;
                r_row_block  <= r_row_block + 6'd1;
            end else begin
                r_glyph_line <= r_glyph_line + 4'd1;
            end
        end
    end

    assign o_row_block  = r_row_block;
    assign o_glyph_line = r_glyph_line;
endmodule

// File: rtl/glyph_frame_sequencer.sv
// Glyph-mode raster sequencer with per-frame palette/scramble animation.
// Optional macro GLYPH_SEQ_LFSR_EN: scramble steps through a 5-bit LFSR instead of a counter.
module glyph_frame_sequencer
    import glyph_seq_pkg::*;
#(
    parameter int GLYPH_H   = DEF_GLYPH_H,
    parameter int H_TOTAL   = DEF_H_TOTAL,
    parameter int V_TOTAL   = DEF_V_TOTAL,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int PALETTE_N = DEF_PALETTE_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              hpos,
    input  logic [9:0]              vpos,
    glyph_frame_sequencer_if.slave  cfg,
    output logic [5:0]              row_block,
    output logic [3:0]              glyph_line,
    output logic [9:0]              frame_cnt,
    output logic [2:0]              palette_idx,
    output logic [4:0]              scramble
);
    localparam logic [2:0] PAL_MASK = 3'(PALETTE_N - 1);

    logic       w_line_end;
    logic       w_boundary;
    logic       w_cfg_ready;
    logic       w_xfer;

    mode_e      r_mode;
    logic [5:0] r_arg;
    logic [5:0] r_rate;
    logic       r_pending;
    logic [7:0] r_pend_data;
    logic [2:0] r_pal;
    logic [4:0] r_scr;
    logic [9:0] r_frame;

    mode_e      w_mode_eff;
    logic [5:0] w_arg_eff;
    logic [5:0] w_rate_eff;
    logic       w_rate_hit;
    mode_e      w_mode_nxt;
    logic [5:0] w_arg_nxt;
    logic [5:0] w_rate_nxt;
    logic [2:0] w_pal_nxt;
    logic [4:0] w_scr_nxt;

    assign w_line_end  = (hpos == 10'(H_TOTAL - 1));
    assign w_boundary  = w_line_end && (vpos == 10'(V_TOTAL - 1));
    assign w_cfg_ready = (vpos >= 10'(V_ACTIVE)) && !r_pending && !w_boundary;
    assign w_xfer      = cfg.cfg_valid && w_cfg_ready;
    assign cfg.cfg_ready = w_cfg_ready;

    glyph_line_counter #(
        .GLYPH_H  (GLYPH_H),
        .V_ACTIVE (V_ACTIVE)
    ) u_line_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_line_end   (w_line_end),
        .i_frame_end  (w_boundary),
        .i_vpos       (vpos),
        .o_row_block  (row_block),
        .o_glyph_line (glyph_line)
    );

    // A pending word takes effect at the boundary before that frame's animation step.
    always_comb begin
        w_mode_eff = r_pending ? mode_e'(r_pend_data[CFG_MODE_LSB +: CFG_MODE_W]) : r_mode;
        w_arg_eff  = r_pending ? r_pend_data[CFG_ARG_LSB +: CFG_ARG_W] : r_arg;
        w_rate_eff = r_pending ? 6'd0 : r_rate;
        w_rate_hit = (w_rate_eff == w_arg_eff);
        w_mode_nxt = r_mode;
        w_arg_nxt  = r_arg;
        w_rate_nxt = r_rate;
        w_pal_nxt  = r_pal;
        w_scr_nxt  = r_scr;
        if (w_boundary) begin
            w_mode_nxt = w_mode_eff;
            w_arg_nxt  = w_arg_eff;
            w_rate_nxt = w_rate_eff;
            case (w_mode_eff)
                MODE_CYCLE: begin
                    if (w_rate_hit) begin
                        w_pal_nxt  = (r_pal + 3'd1) & PAL_MASK;
                        w_rate_nxt = 6'd0;
                    end else begin
                        w_rate_nxt = w_rate_eff + 6'd1;
                    end
                end
                MODE_SCRAMBLE: begin
                    if (w_rate_hit) begin
                        w_scr_nxt  = scramble_step(r_scr);
                        w_rate_nxt = 6'd0;
                    end else begin
                        w_rate_nxt = w_rate_eff + 6'd1;
                    end
                end
                default: w_pal_nxt = w_arg_eff[2:0] & PAL_MASK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= MODE_STATIC;
            r_arg       <= '0;
            r_rate      <= '0;
            r_pending   <= 1'b0;
            r_pend_data <= '0;
            r_pal       <= '0;
            r_scr       <= SCRAMBLE_SEED;
            r_frame     <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_arg  <= w_arg_nxt;
            r_rate <= w_rate_nxt;
            r_pal  <= w_pal_nxt;
            r_scr  <= w_scr_nxt;
            if (w_boundary) begin
                r_pending <= 1'b0;
                r_frame   <= r_frame + 10'd1;
            end else if (w_xfer) begin
                r_pending   <= 1'b1;
                r_pend_data <= cfg.cfg_data;
            end
        end
    end

    assign frame_cnt   = r_frame;
    assign palette_idx = r_pal;
    assign scramble    = r_scr;
endmodule

// File: doc/glyph_frame_sequencer.md
Name: glyph_frame_sequencer

Overview:
Sequences the glyph-mode pixel datapath. Tracks raster position to produce the glyph row index and the line within the glyph for every line, so no per-pixel divide-by-12 is needed. Also runs a per-frame animation scheduler (palette cycling, glyph scramble seed) configured through a valid/ready port. Sits between hvsync_generator and the glyph ROM/palette lookup in the top level.

Parameters:
GLYPH_H, 12, glyph height in lines
H_TOTAL, 800, clocks per line
V_TOTAL, 525, lines per frame
V_ACTIVE, 480, visible lines
PALETTE_N, 8, palette entries (power of two)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
hpos  in  10  current pixel column from hvsync_generator
vpos  in  10  current line from hvsync_generator
cfg_valid  in  1  config word offered
cfg_data  in  8  [1:0] mode, [7:2] arg
cfg_ready  out  1  config word can be accepted this cycle
row_block  out  6  glyph row index, 0..V_ACTIVE/GLYPH_H-1
glyph_line  out  4  line within glyph, 0..GLYPH_H-1
frame_cnt  out  10  frames since reset, wraps 1023->0
palette_idx  out  3  active palette entry
scramble  out  5  glyph index XOR seed for current frame

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0 except scramble=5'b00001 (LFSR build). Mode=STATIC, arg=0, no pending config, rate_cnt=0. Reset mid-frame takes effect at the next edge regardless of raster position.
- All outputs registered. Line advance: on the edge where hpos==H_TOTAL-1, outputs update to describe line vpos+1.
  - glyph_line increments; at GLYPH_H-1 it wraps to 0 and row_block increments.
  - While vpos+1 >= V_ACTIVE, row_block and glyph_line hold.
- Frame boundary: the edge where hpos==H_TOTAL-1 and vpos==V_TOTAL-1.
  - row_block and glyph_line go to 0.
  - frame_cnt increments.
  - A pending config is applied: mode/arg load, rate_cnt clears, pending clears.
  - The animation step then runs with the new config.
- Config handshake:
  - cfg_ready = (vpos >= V_ACTIVE) && !pending && !(frame-boundary cycle).
  - A transfer occurs when cfg_valid && cfg_ready; the word is latched into pending.
  - Only one word is held. Later offers stall (cfg_ready=0) until that word is applied.
  - A transfer and the frame boundary can never coincide, because cfg_ready is low on the boundary cycle.
- Animation FSM. Mode decode: 0 STATIC, 1 CYCLE, 2 SCRAMBLE, 3 reserved (behaves as STATIC).
  - STATIC: palette_idx=arg[2:0]; scramble holds.
  - CYCLE: each boundary, if rate_cnt==arg then palette_idx=(palette_idx+1) mod PALETTE_N and rate_cnt=0, else rate_cnt+1. palette_idx 7 wraps to 0. scramble holds.
  - SCRAMBLE: palette_idx holds. The scramble step fires every arg+1 frames, using the same rate_cnt rule.
- rate_cnt is 6 bits wide. arg=0 means a step every frame.

Optional Feature:
Macro GLYPH_SEQ_LFSR_EN.
- Defined: a scramble step is a 5-bit Fibonacci LFSR, s <= {s[3:0], s[4]^s[2]}. Period 31; never 0. Reset value 5'b00001.
- Undefined: a scramble step is s <= s+1, wrapping 31->0. Reset value 5'b00000.

Decomposition:
- Package glyph_seq_pkg holds:
  - the mode enum (MODE_STATIC, MODE_CYCLE, MODE_SCRAMBLE, MODE_RSVD);
  - cfg field bit positions;
  - the default timing constants;
  - the LFSR reset seed.
- One sub-module, glyph_line_counter: the line/row counter with its frame reset. The animation FSM and config port stay in the parent.

Test Plan:
- Reset then run to vpos=11→12 boundary -> glyph_line 11→0, row_block 0→1. At vpos=479→480 -> row_block=39, glyph_line=11, then hold through blanking.
- Run to hpos=799,vpos=524 -> next cycle row_block=0, glyph_line=0, frame_cnt=1. Repeat 1024 frames -> frame_cnt wraps to 0.
- cfg_valid=1 during vpos<480 -> cfg_ready=0, no transfer. Hold cfg_valid into vpos=480 -> transfer, then cfg_ready=0 until the boundary, config applied at the boundary.
- Config mode=CYCLE, arg=2 -> palette_idx 0,0,0,1,1,1,2… advancing every 3 frames; after 24 frames it is back at 0. Then config STATIC arg=5 -> palette_idx=5 from the next frame.
- SCRAMBLE arg=0 with GLYPH_SEQ_LFSR_EN -> scramble 00001,00010,00100,01001,10010,… and repeats after 31 frames. Without the macro -> 0,1,2,3… and 31→0.
- Assert rst_n=0 for one cycle mid-frame (vpos=200, CYCLE mode) -> all outputs are their reset values on the next cycle, mode is STATIC, pending is cleared.
